// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the multi-ported register file.
package regfile_pkg;
  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [XLEN_DEFAULT-1:0] word_t;

  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: a claim marks a register pending, any write to it clears it.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int AW    = addr_width(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             claim_i,
  input  logic [AW-1:0]    claim_add_i,
  input  logic [NREGS-1:0] clr_i,
  output logic [NREGS-1:0] busy_o
);

  logic [NREGS-1:0] busy_q, busy_d;

  // Claim is applied after the clear so a same-cycle claim wins.
  always_comb begin
    busy_d = busy_q & ~clr_i;
    if (claim_i && (claim_add_i != '0)) begin
      busy_d[claim_add_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported register file with hard-wired x0, optional write-to-read bypass
// and a busy scoreboard for issued-but-unwritten results.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NREGS    = NREGS_DEFAULT,
  parameter int NR_READ  = 2,
  parameter int NR_WRITE = 1,
  parameter int BYPASS   = 1,
  parameter int AW       = addr_width(NREGS)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NR_READ-1:0][AW-1:0]         rs_add_i,
  output logic [NR_READ-1:0][XLEN-1:0]       rs_data_o,
  output logic [NR_READ-1:0]                 rs_busy_o,
  input  logic [NR_WRITE-1:0]                we_i,
  input  logic [NR_WRITE-1:0][AW-1:0]        rd_add_i,
  input  logic [NR_WRITE-1:0][XLEN-1:0]      rd_data_i,
  input  logic                               claim_i,
  input  logic [AW-1:0]                      claim_add_i
);

  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           clr_vec;
  logic [NREGS-1:0]           busy;
  logic [NR_READ-1:0]         fwd;

  // Later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    regs_d  = regs_q;
    clr_vec = '0;
    for (int w = 0; w < NR_WRITE; w++) begin
      if (we_i[w]) begin
        clr_vec[rd_add_i[w]] = 1'b1;
        if (rd_add_i[w] != '0) begin
          regs_d[rd_add_i[w]] = rd_data_i[w];
        end
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .claim_i     (claim_i),
    .claim_add_i (claim_add_i),
    .clr_i       (clr_vec),
    .busy_o      (busy)
  );

  // A forwarded read carries the value being written, so it is never busy.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    fwd       = '0;
    for (int k = 0; k < NR_READ; k++) begin
      rs_data_o[k] = regs_q[rs_add_i[k]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NR_WRITE; w++) begin
          if (we_i[w] && (rd_add_i[w] == rs_add_i[k]) && (rs_add_i[k] != '0)) begin
            rs_data_o[k] = rd_data_i[w];
            fwd[k]       = 1'b1;
          end
        end
      end
      rs_busy_o[k] = busy[rs_add_i[k]] & ~fwd[k];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios on a bypassing and a non-bypassing
// instance, plus a randomized regression of a wide 16-entry instance.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // m: 32x32, 2 read, 2 write, bypass
  logic [1:0][4:0]  m_rs_add;
  word_t [1:0]      m_rs_data;
  logic [1:0]       m_rs_busy;
  logic [1:0]       m_we;
  logic [1:0][4:0]  m_rd_add;
  word_t [1:0]      m_rd_data;
  logic             m_claim;
  logic [4:0]       m_claim_add;

  // n: 32x32, 2 read, 1 write, no bypass
  logic [1:0][4:0]  n_rs_add;
  word_t [1:0]      n_rs_data;
  logic [1:0]       n_rs_busy;
  logic [0:0]       n_we;
  logic [0:0][4:0]  n_rd_add;
  word_t [0:0]      n_rd_data;
  logic             n_claim;
  logic [4:0]       n_claim_add;

  // r: 64-bit x16, 3 read, 2 write, bypass
  logic [2:0][3:0]  r_rs_add;
  logic [2:0][63:0] r_rs_data;
  logic [2:0]       r_rs_busy;
  logic [1:0]       r_we;
  logic [1:0][3:0]  r_rd_add;
  logic [1:0][63:0] r_rd_data;
  logic             r_claim;
  logic [3:0]       r_claim_add;

  regfile_mp #(.XLEN(32), .NREGS(32), .NR_READ(2), .NR_WRITE(2), .BYPASS(1)) dut_m (
    .clk_i(clk), .rst_i(rst), .rs_add_i(m_rs_add), .rs_data_o(m_rs_data),
    .rs_busy_o(m_rs_busy), .we_i(m_we), .rd_add_i(m_rd_add), .rd_data_i(m_rd_data),
    .claim_i(m_claim), .claim_add_i(m_claim_add));

  regfile_mp #(.XLEN(32), .NREGS(32), .NR_READ(2), .NR_WRITE(1), .BYPASS(0)) dut_n (
    .clk_i(clk), .rst_i(rst), .rs_add_i(n_rs_add), .rs_data_o(n_rs_data),
    .rs_busy_o(n_rs_busy), .we_i(n_we), .rd_add_i(n_rd_add), .rd_data_i(n_rd_data),
    .claim_i(n_claim), .claim_add_i(n_claim_add));

  regfile_mp #(.XLEN(64), .NREGS(16), .NR_READ(3), .NR_WRITE(2), .BYPASS(1)) dut_r (
    .clk_i(clk), .rst_i(rst), .rs_add_i(r_rs_add), .rs_data_o(r_rs_data),
    .rs_busy_o(r_rs_busy), .we_i(r_we), .rd_add_i(r_rd_add), .rd_data_i(r_rd_data),
    .claim_i(r_claim), .claim_add_i(r_claim_add));

  // Reference state for the regression instance.
  logic [63:0] mdl_regs [16];
  logic        mdl_busy [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_rs_add = '0; m_we = '0; m_rd_add = '0; m_rd_data = '0; m_claim = 1'b0; m_claim_add = '0;
    n_rs_add = '0; n_we = '0; n_rd_add = '0; n_rd_data = '0; n_claim = 1'b0; n_claim_add = '0;
    r_rs_add = '0; r_we = '0; r_rd_add = '0; r_rd_data = '0; r_claim = 1'b0; r_claim_add = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      m_rs_add[0] = 5'(a);
      m_rs_add[1] = 5'(a + 1);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (m_rs_data[k] !== 32'h0) begin
          errors++;
          $display("FAIL reset_data x%0d: got %h expected 0", a + k, m_rs_data[k]);
        end
        checks++;
        if (m_rs_busy[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_busy x%0d: got %b expected 0", a + k, m_rs_busy[k]);
        end
      end
      tick();
    end
    idle();
    m_we[0] = 1'b1; m_rd_add[0] = 5'd0; m_rd_data[0] = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (m_rs_data[0] !== 32'h0) begin
      errors++;
      $display("FAIL x0_no_bypass: got %h expected 0", m_rs_data[0]);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (m_rs_data[0] !== 32'h0) begin
      errors++;
      $display("FAIL x0_after_write: got %h expected 0", m_rs_data[0]);
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    m_we[0] = 1'b1; m_rd_add[0] = 5'd5; m_rd_data[0] = 32'h12345678; m_rs_add[0] = 5'd5;
    n_we[0] = 1'b1; n_rd_add[0] = 5'd5; n_rd_data[0] = 32'h12345678; n_rs_add[0] = 5'd5;
    @(negedge clk);
    checks++;
    if (m_rs_data[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_same_cycle: got %h expected 12345678", m_rs_data[0]);
    end
    checks++;
    if (n_rs_data[0] !== 32'h0) begin
      errors++;
      $display("FAIL nobypass_same_cycle: got %h expected 0", n_rs_data[0]);
    end
    tick();
    idle();
    m_rs_add[0] = 5'd5;
    n_rs_add[0] = 5'd5;
    @(negedge clk);
    checks++;
    if (m_rs_data[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_next_cycle: got %h expected 12345678", m_rs_data[0]);
    end
    checks++;
    if (n_rs_data[0] !== 32'h12345678) begin
      errors++;
      $display("FAIL nobypass_next_cycle: got %h expected 12345678", n_rs_data[0]);
    end
    tick();
  endtask

  task automatic test_port_priority();
    idle();
    m_we = 2'b11;
    m_rd_add[0] = 5'd7; m_rd_data[0] = 32'hA;
    m_rd_add[1] = 5'd7; m_rd_data[1] = 32'hB;
    m_rs_add[0] = 5'd7; m_rs_add[1] = 5'd7;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (m_rs_data[k] !== 32'hB) begin
        errors++;
        $display("FAIL priority_bypass rs%0d: got %h expected b", k, m_rs_data[k]);
      end
    end
    tick();
    idle();
    m_rs_add[1] = 5'd7;
    @(negedge clk);
    checks++;
    if (m_rs_data[1] !== 32'hB) begin
      errors++;
      $display("FAIL priority_stored: got %h expected b", m_rs_data[1]);
    end
    tick();
  endtask

  task automatic test_busy();
    idle();
    m_claim = 1'b1; m_claim_add = 5'd3; m_rs_add[0] = 5'd3;
    @(negedge clk);
    checks++;
    if (m_rs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL busy_before_edge: got %b expected 0", m_rs_busy[0]);
    end
    tick();
    m_claim = 1'b1; m_claim_add = 5'd3;
    @(negedge clk);
    checks++;
    if (m_rs_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_claim: got %b expected 1", m_rs_busy[0]);
    end
    tick();
    idle();
    m_rs_add[0] = 5'd3;
    @(negedge clk);
    checks++;
    if (m_rs_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL busy_reclaim: got %b expected 1", m_rs_busy[0]);
    end
    m_we[0] = 1'b1; m_rd_add[0] = 5'd3; m_rd_data[0] = 32'h55;
    #1;
    checks++;
    if (m_rs_busy[0] !== 1'b0 || m_rs_data[0] !== 32'h55) begin
      errors++;
      $display("FAIL busy_forwarded: got busy=%b data=%h expected busy=0 data=55",
               m_rs_busy[0], m_rs_data[0]);
    end
    tick();
    idle();
    m_rs_add[0] = 5'd3;
    @(negedge clk);
    checks++;
    if (m_rs_busy[0] !== 1'b0 || m_rs_data[0] !== 32'h55) begin
      errors++;
      $display("FAIL busy_cleared: got busy=%b data=%h expected busy=0 data=55",
               m_rs_busy[0], m_rs_data[0]);
    end
    m_claim = 1'b1; m_claim_add = 5'd3;
    m_we[1] = 1'b1; m_rd_add[1] = 5'd3; m_rd_data[1] = 32'h66;
    tick();
    idle();
    m_rs_add[0] = 5'd3;
    @(negedge clk);
    checks++;
    if (m_rs_busy[0] !== 1'b1 || m_rs_data[0] !== 32'h66) begin
      errors++;
      $display("FAIL claim_and_write: got busy=%b data=%h expected busy=1 data=66",
               m_rs_busy[0], m_rs_data[0]);
    end
    m_claim = 1'b1; m_claim_add = 5'd0;
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (m_rs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL x0_never_busy: got %b expected 0", m_rs_busy[0]);
    end
    tick();
  endtask

  task automatic test_reset_discard();
    idle();
    m_we[0] = 1'b1; m_rd_add[0] = 5'd9; m_rd_data[0] = 32'h11;
    tick();
    idle();
    m_claim = 1'b1; m_claim_add = 5'd9;
    tick();
    idle();
    m_rs_add[0] = 5'd9;
    @(negedge clk);
    checks++;
    if (m_rs_busy[0] !== 1'b1 || m_rs_data[0] !== 32'h11) begin
      errors++;
      $display("FAIL pre_reset_x9: got busy=%b data=%h expected busy=1 data=11",
               m_rs_busy[0], m_rs_data[0]);
    end
    rst = 1'b1;
    m_claim = 1'b1; m_claim_add = 5'd9;
    m_we[1] = 1'b1; m_rd_add[1] = 5'd9; m_rd_data[1] = 32'h77;
    #1;
    checks++;
    if (m_rs_data[0] !== 32'h77 || m_rs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_cycle_bypass: got busy=%b data=%h expected busy=0 data=77",
               m_rs_busy[0], m_rs_data[0]);
    end
    tick();
    rst = 1'b0;
    idle();
    m_rs_add[0] = 5'd9;
    @(negedge clk);
    checks++;
    if (m_rs_data[0] !== 32'h0 || m_rs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard_x9: got busy=%b data=%h expected busy=0 data=0",
               m_rs_busy[0], m_rs_data[0]);
    end
    tick();
  endtask

  task automatic test_regression();
    logic [63:0] exp_data;
    logic        exp_busy;
    idle();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      rst = (cyc == 0) || ($urandom_range(0, 499) == 0);
      for (int w = 0; w < 2; w++) begin
        r_we[w]      = ($urandom_range(0, 2) != 0);
        r_rd_add[w]  = 4'($urandom_range(0, 15));
        r_rd_data[w] = {$urandom, $urandom};
      end
      if ($urandom_range(0, 3) == 0) r_rd_add[1] = r_rd_add[0];
      r_claim     = ($urandom_range(0, 2) == 0);
      r_claim_add = ($urandom_range(0, 3) == 0) ? r_rd_add[0] : 4'($urandom_range(0, 15));
      for (int k = 0; k < 3; k++) begin
        r_rs_add[k] = ($urandom_range(0, 3) == 0) ? r_rd_add[$urandom_range(0, 1)]
                                                  : 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        int a;
        a = int'(r_rs_add[k]);
        exp_data = mdl_regs[a];
        exp_busy = mdl_busy[a];
        for (int w = 0; w < 2; w++) begin
          if (r_we[w] && int'(r_rd_add[w]) == a && a != 0) begin
            exp_data = r_rd_data[w];
            exp_busy = 1'b0;
          end
        end
        checks++;
        if (r_rs_data[k] !== exp_data) begin
          errors++;
          $display("FAIL regr_data cyc=%0d rs%0d x%0d: got %h expected %h",
                   cyc, k, a, r_rs_data[k], exp_data);
        end
        checks++;
        if (r_rs_busy[k] !== exp_busy) begin
          errors++;
          $display("FAIL regr_busy cyc=%0d rs%0d x%0d: got %b expected %b",
                   cyc, k, a, r_rs_busy[k], exp_busy);
        end
      end
      if (rst) begin
        for (int i = 0; i < 16; i++) begin
          mdl_regs[i] = '0;
          mdl_busy[i] = 1'b0;
        end
      end else begin
        for (int w = 0; w < 2; w++) begin
          if (r_we[w]) begin
            if (r_rd_add[w] != 4'd0) mdl_regs[r_rd_add[w]] = r_rd_data[w];
            mdl_busy[r_rd_add[w]] = 1'b0;
          end
        end
        if (r_claim && r_claim_add != 4'd0) mdl_busy[r_claim_add] = 1'b1;
      end
      tick();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    for (int i = 0; i < 16; i++) begin
      mdl_regs[i] = '0;
      mdl_busy[i] = 1'b0;
    end
    test_reset();
    test_bypass();
    test_port_priority();
    test_busy();
    test_reset_discard();
    test_regression();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: data word width in bits.
REQ-002 SHALL have parameter NREGS, default 32: number of architectural registers (power of 2, >= 2).
REQ-003 SHALL have parameter NR_READ, default 2: number of read ports.
REQ-004 SHALL have parameter NR_WRITE, default 1: number of write ports.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 SHALL derive AW = $clog2(NREGS) as the address width.
REQ-007 SHALL use one clock and a synchronous, active-high reset.
REQ-008 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-009 rst_i  input  1  synchronous reset.
REQ-010 rs_add_i  input  [NR_READ][AW]  read addresses.
REQ-011 rs_data_o  output  [NR_READ][XLEN]  read data.
REQ-012 rs_busy_o  output  [NR_READ]  register has a pending, unwritten result.
REQ-013 we_i  input  [NR_WRITE]  write enables.
REQ-014 rd_add_i  input  [NR_WRITE][AW]  write addresses.
REQ-015 rd_data_i  input  [NR_WRITE][XLEN]  write data.
REQ-016 claim_i  input  1  marks claim_add_i as pending (instruction issued).
REQ-017 claim_add_i  input  [AW]  register being claimed.

Function
REQ-018 Register 0 SHALL always read 0, SHALL ignore writes, and SHALL never be busy.
REQ-019 Reads SHALL be combinational (zero latency) from the register array.
REQ-020 With BYPASS=1, a read whose address matches an enabled same-cycle write to a nonzero register SHALL return that write's rd_data_i.
REQ-021 When several write ports target the same register in one cycle, the highest-indexed port SHALL win, for both storage and bypass.
REQ-022 Writes SHALL update the array on the rising edge after we_i is sampled high (1-cycle write latency).
REQ-023 A scoreboard of NREGS busy bits SHALL set busy[claim_add_i] on the edge where claim_i=1 and claim_add_i != 0.
REQ-024 Any enabled write to register r SHALL clear busy[r] on the same edge.
REQ-025 A claim and a write to the same register in the same cycle SHALL leave busy[r]=1, with the new claim taking precedence.
REQ-026 rs_busy_o[k] SHALL equal busy[rs_add_i[k]]; with BYPASS=1 it SHALL be 0 when that read is being forwarded in the same cycle.
REQ-027 A claim on an already-busy register SHALL keep it busy; there is no claim counting.

Reset
REQ-028 On an rst_i-high edge, all registers SHALL clear to 0 and all busy bits SHALL clear to 0.
REQ-029 Writes and claims presented in a reset cycle SHALL be discarded, with reset taking priority.
REQ-030 During reset, outputs SHALL stay combinational: rs_data_o shows the current array contents plus any bypass, and rs_busy_o shows the current busy bits.

Structure
REQ-031 Package regfile_pkg SHALL hold the default constants (XLEN, NREGS), the word_t typedef, and an AW helper function.
REQ-032 The scoreboard SHALL be a separate sub-module regfile_scoreboard (busy vector plus claim/clear logic), instantiated once.

Verification
REQ-033 Reset, then read x0..x31 -> all data 0 and all busy 0; write x0=0xDEADBEEF, then read x0 -> 0.
REQ-034 Write x5=0x12345678 with rs_add_i[0]=5 in the same cycle -> BYPASS=1 reads 0x12345678 that cycle; BYPASS=0 reads the old value, then 0x12345678 the next cycle.
REQ-035 NR_WRITE=2: port0 writes x7=0xA, port1 writes x7=0xB in the same cycle -> x7 reads 0xB afterwards and the bypass shows 0xB.
REQ-036 Claim x3, then read x3 -> busy=1; write x3=0x55 -> busy=0 the next cycle; claim and write x3 in the same cycle -> busy stays 1.
REQ-037 Claim x9 and write x9=0x77 while rst_i=1 -> after reset x9=0 and busy[9]=0.
REQ-038 Regression with XLEN=64, NREGS=16, NR_READ=3: random writes checked against a reference model -> zero mismatches over 10k cycles.
